// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Free-running Moore sequencer that feeds a fixed 7-entry operand/opcode
// program to a downstream add/subtract ALU. S0 is a reset-only idle state.
// After reset the sequence is S1..S7, and then it wraps back to S1.
// Outputs are a pure combinational decode of pstate. There is no output
// register, so A/B/OP move in the same cycle as the state.
module alu_operand_sequencer #(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             OP
);

   typedef enum logic [2:0] {
      S0 = 3'b000,
      S1 = 3'b001,
      S2 = 3'b010,
      S3 = 3'b011,
      S4 = 3'b100,
      S5 = 3'b101,
      S6 = 3'b110,
      S7 = 3'b111
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   state_t pstate;
   state_t nstate;

   // State register; a synchronous reset parks the machine in idle S0
   always_ff @(posedge clk) begin
      if (reset) pstate <= S0;
      else       pstate <= nstate;
   end

   // Next state: a linear walk. S7 wraps to S1, so S0 is reachable only via reset
   always_comb begin
      nstate = S0;
      case (pstate)
         S0:      nstate = S1;
         S1:      nstate = S2;
         S2:      nstate = S3;
         S3:      nstate = S4;
         S4:      nstate = S5;
         S5:      nstate = S6;
         S6:      nstate = S7;
         S7:      nstate = S1;
         default: nstate = S0;
      endcase
   end

   // Moore output decode; each state sources one ALU corner case
   always_comb begin
      A  = '0;
      B  = '0;
      OP = OP_ADD;
      case (pstate)
         S0: begin                      // idle / clear
            A  = '0;
            B  = '0;
            OP = OP_ADD;
         end
         S1: begin                      // simple add
            A  = WIDTH'(5);
            B  = WIDTH'(3);
            OP = OP_ADD;
         end
         S2: begin                      // simple subtract
            A  = WIDTH'(5);
            B  = WIDTH'(3);
            OP = OP_SUB;
         end
         S3: begin                      // largest sum that still fits
            A  = WIDTH'(100);
            B  = WIDTH'(27);
            OP = OP_ADD;
         end
         S4: begin                      // add overflow
            A  = WIDTH'(127);
            B  = WIDTH'(1);
            OP = OP_ADD;
         end
         S5: begin                      // subtract underflow
            A  = '0;
            B  = WIDTH'(1);
            OP = OP_SUB;
         end
         S6: begin                      // subtract to zero
            A  = WIDTH'(127);
            B  = WIDTH'(127);
            OP = OP_SUB;
         end
         S7: begin                      // mid-range add
            A  = WIDTH'(64);
            B  = WIDTH'(63);
            OP = OP_ADD;
         end
         default: begin
            A  = '0;
            B  = '0;
            OP = OP_ADD;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer
// Runs directed reset/wrap scenarios, followed by a randomized reset pattern.
// Each cycle is compared against a model that counts cycles since the last
// reset: 0 cycles means idle, and otherwise the position in the 7-step
// program is ((k-1) mod 7)+1.
module tb_alu_operand_sequencer;

   logic       clk;
   logic       reset;
   logic [6:0] A;
   logic [6:0] B;
   logic       OP;

   int checks;
   int errors;
   int k;          // cycles since last reset edge, -1 = never reset

   alu_operand_sequencer #(.WIDTH(7)) dut (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .B     (B),
      .OP    (OP)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d (k=%0d t=%0t)", tag, obs, exp, k, $time);
      end
   endtask

   // Program table as written out in the operand list: {A, B, OP}
   function automatic int exp_a(input int st);
      int t[8] = '{0, 5, 5, 100, 127, 0, 127, 64};
      return t[st];
   endfunction
   function automatic int exp_b(input int st);
      int t[8] = '{0, 3, 3, 27, 1, 1, 127, 63};
      return t[st];
   endfunction
   function automatic int exp_op(input int st);
      int t[8] = '{0, 0, 1, 0, 0, 1, 1, 0};
      return t[st];
   endfunction

   // Drive reset for one cycle, advance the model, and check outputs just after the edge
   task automatic cycle(input logic r);
      int st;
      @(negedge clk);
      reset = r;
      @(posedge clk);
      if (r)           k = 0;
      else if (k >= 0) k++;
      #1;
      if (k >= 0) begin
         st = (k == 0) ? 0 : ((k - 1) % 7) + 1;
         chk("pstate", int'(dut.pstate), st);
         chk("A",      int'(A),          exp_a(st));
         chk("B",      int'(B),          exp_b(st));
         chk("OP",     int'(OP),         exp_op(st));
      end
   endtask

   int op_ones;

   initial begin
      checks = 0;
      errors = 0;
      k      = -1;
      reset  = 1'b1;

      // Single reset edge, then free-run through more than one full period
      cycle(1'b1);
      for (int i = 0; i < 10; i++) cycle(1'b0);

      // Run to S5 (k=5 after reset), then hit it with reset
      cycle(1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0);
      chk("at_s5_op", int'(OP), 1);
      cycle(1'b1);
      cycle(1'b0);

      // Hold reset for three edges, then release
      for (int i = 0; i < 3; i++) cycle(1'b1);
      for (int i = 0; i < 8; i++) cycle(1'b0);

      // Over one full period, OP should be high in exactly three states
      cycle(1'b1);
      op_ones = 0;
      for (int i = 0; i < 7; i++) begin
         cycle(1'b0);
         op_ones += int'(OP);
      end
      chk("op_ones_per_period", op_ones, 3);

      // Randomized reset pattern
      for (int i = 0; i < 400; i++)
         cycle(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
